mc_stage_ctrl: RTL
==================

# mc_stage_ctrl

Parametrised Monte Carlo simulation-engine controller, the successor to the fixed five-stage engine controller. It sequences an N-stage Heston path pipeline through fill, run and drain. Stage enables are thermometer-coded, and each stage applies back-pressure through its own ready line. The block counts time steps and paths, so a single `load` runs a complete batch of `num_paths` × `num_steps` steps. It sits between the pricer's host/config interface and the path-generation datapath.

## Interface
Parameters:
- `NUM_STAGES`, default 5: number of pipeline stages (≥2); width of the enable vector.
- `PATH_W`, default 16: path counter width.
- `STEP_W`, default 12: time-step counter width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `load`, in, 1: start a batch; sampled only in IDLE.
- `num_paths`, in, `PATH_W`: paths per batch; latched on an accepted `load`.
- `num_steps`, in, `STEP_W`: steps per path; latched on an accepted `load`.
- `stage_ready`, in, `NUM_STAGES`: per-stage ready/back-pressure.
- `abort`, in, 1: terminate the batch and drain.
- `mc_output_ctrl`, out, `NUM_STAGES`: thermometer stage enables, registered.
- `step_valid`, out, 1: step accepted this cycle; combinational, equal to RUN & (&`stage_ready`).
- `step_idx`, out, `STEP_W`: current step, registered.
- `path_idx`, out, `PATH_W`: current path, registered.
- `path_done`, out, 1: one-cycle pulse at the end of each path, registered.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: high in IDLE, registered.
- `stall_cycles`, out, 32: count of RUN cycles stalled by back-pressure (see Configuration).

## Operation
States: IDLE, FILL, RUN, DRAIN.

- **Reset values:** state IDLE, `mc_output_ctrl`=0, `step_idx`=0, `path_idx`=0, `path_done`=0, `done`=1, `busy`=0, `stall_cycles`=0. `rst` overrides everything, including mid-batch.
- **IDLE:**
  - `load` with `num_paths`≠0 and `num_steps`≠0: latch both values, clear the counters, set `mc_output_ctrl`=…0001, go to FILL.
  - `load` with a zero count: ignored; `done` stays 1.
- **FILL:**
  - If `stage_ready[k]` is high, where k is the highest enabled stage, set enable bit k+1.
  - When bit `NUM_STAGES`-1 becomes set, go to RUN.
  - If not ready, hold.
- **RUN:**
  - If all `stage_ready` are high, the step is accepted and `step_idx` increments.
  - On the step where `step_idx`=`num_steps`-1: `step_idx`→0, `path_idx`++, `path_done`=1 for the next cycle.
  - If that path was also path `num_paths`-1, go to DRAIN instead; `path_idx` then holds `num_paths`.
  - Any ready low: stall, counters hold.
- **DRAIN:**
  - Clear the lowest set enable bit each cycle (11111→11110→…→00000), ignoring ready.
  - On the cycle that clears the final bit, go to IDLE and set `done`=1.
- **abort** in FILL or RUN: go to DRAIN on the next edge.
  - The step in that cycle is not counted, and `path_done` is not pulsed.
  - `abort` in DRAIN or IDLE has no effect.
- **load** outside IDLE is ignored. `load` on the same edge as the DRAIN→IDLE transition is also ignored.
- **Counter width:** counters are sized by `PATH_W`/`STEP_W`; a full-scale `num_steps` wraps `step_idx` to 0 exactly at the path end.

## Timing
- Edge E0 samples `load`. After E0, `mc_output_ctrl`=00001 and `done`=0 (`NUM_STAGES`=5, all stages ready).
- Full enables appear after E0+`NUM_STAGES`-1; the first step can be accepted at edge E`NUM_STAGES`.
- With no stalls, `done` rises after edge E0 + 2·`NUM_STAGES` − 1 + `num_paths`·`num_steps`.
- Each stall cycle (FILL or RUN) adds one cycle.
- `path_done` is high for exactly one cycle, aligned with `step_idx` returning to 0.

## Configuration
- Macro `MC_STAGE_CTRL_PERF_CNT_EN`.
- **Defined:** `stall_cycles` increments on every RUN cycle where `step_valid`=0. It saturates at 2^32−1 and clears on an accepted `load` and on reset.
- **Undefined:** the counter logic is omitted and `stall_cycles` is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** `rst`=1 for 2 cycles → `mc_output_ctrl`=00000, `done`=1, `busy`=0, `path_idx`=0, `step_idx`=0.
- **Full batch:** `load`, `num_paths`=2, `num_steps`=3, all ready.
  - Enables go 00001→00011→00111→01111→11111 on successive edges.
  - 6 `step_valid` cycles; `path_done` pulses twice.
  - Drain 11110→…→00000; `done`=1 exactly 15 cycles after E0.
- **Back-pressure:** `stage_ready[2]` low for 4 cycles mid-RUN → `step_idx` holds, `done` is delayed 4 cycles, and `stall_cycles`=4 (macro defined) or 0 (undefined).
- **Ignored loads:** `load` with `num_paths`=0 → remains IDLE, `done`=1. `load` pulsed during RUN → no effect on counters.
- **Abort:** assert `abort` in RUN with `step_idx`=1 → drain starts on the next edge, no `path_done` pulse, IDLE after `NUM_STAGES` cycles.
- **Parametrisation and mid-batch reset:** `NUM_STAGES`=8 → 8-bit thermometer fill and drain. `rst` asserted mid-FILL → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/mc_stage_ctrl.sv
// Monte Carlo path-pipeline controller: thermometer fill, step/path counting, drain.
// Optional stall counter is enabled by defining MC_STAGE_CTRL_PERF_CNT_EN.
module mc_stage_ctrl #(
   parameter int unsigned NUM_STAGES = 5,
   parameter int unsigned PATH_W     = 16,
   parameter int unsigned STEP_W     = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [PATH_W-1:0]     num_paths,
   input  logic [STEP_W-1:0]     num_steps,
   input  logic [NUM_STAGES-1:0] stage_ready,
   input  logic                  abort,
   output logic [NUM_STAGES-1:0] mc_output_ctrl,
   output logic                  step_valid,
   output logic [STEP_W-1:0]     step_idx,
   output logic [PATH_W-1:0]     path_idx,
   output logic                  path_done,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           stall_cycles
);

   typedef enum logic [1:0] {StIdle, StFill, StRun, StDrain} state_e;

   state_e                state_q;
   logic [NUM_STAGES-1:0] ctrl_q;
   logic [STEP_W-1:0]     step_q;
   logic [STEP_W-1:0]     num_steps_q;
   logic [PATH_W-1:0]     path_q;
   logic [PATH_W-1:0]     num_paths_q;
   logic                  path_done_q;
   logic                  done_q;

   logic [NUM_STAGES-1:0] top_en;
   logic [NUM_STAGES-1:0] ctrl_drop;
   logic                  top_ready;
   logic                  all_ready;
   logic                  load_ok;
   logic                  last_step;
   logic                  last_path;

   // One-hot of the highest enabled stage; only its ready gates the next fill step.
   assign top_en    = ctrl_q & ~(ctrl_q >> 1);
   assign top_ready = |(top_en & stage_ready);
   assign ctrl_drop = ctrl_q & (ctrl_q - NUM_STAGES'(1));
   assign all_ready = &stage_ready;
   assign load_ok   = (state_q == StIdle) && load && (num_paths != '0) && (num_steps != '0);
   assign last_step = (step_q == num_steps_q - STEP_W'(1));
   assign last_path = (path_q == num_paths_q - PATH_W'(1));

   assign step_valid     = (state_q == StRun) && all_ready;
   assign mc_output_ctrl = ctrl_q;
   assign step_idx       = step_q;
   assign path_idx       = path_q;
   assign path_done      = path_done_q;
   assign done           = done_q;
   assign busy           = (state_q != StIdle);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         ctrl_q      <= '0;
         step_q      <= '0;
         path_q      <= '0;
         num_steps_q <= '0;
         num_paths_q <= '0;
         path_done_q <= 1'b0;
         done_q      <= 1'b1;
      end else begin
         path_done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (load_ok) begin
                  num_paths_q <= num_paths;
                  num_steps_q <= num_steps;
                  step_q      <= '0;
                  path_q      <= '0;
                  ctrl_q      <= NUM_STAGES'(1);
                  done_q      <= 1'b0;
                  state_q     <= StFill;
               end
            end
            StFill: begin
               if (abort) begin
                  state_q <= StDrain;
               end else if (top_ready) begin
                  ctrl_q <= {ctrl_q[NUM_STAGES-2:0], 1'b1};
                  if (ctrl_q[NUM_STAGES-2]) state_q <= StRun;
               end
            end
            StRun: begin
               if (abort) begin
                  state_q <= StDrain;
               end else if (all_ready) begin
                  if (last_step) begin
                     step_q      <= '0;
                     path_q      <= path_q + PATH_W'(1);
                     path_done_q <= 1'b1;
                     if (last_path) state_q <= StDrain;
                  end else begin
                     step_q <= step_q + STEP_W'(1);
                  end
               end
            end
            StDrain: begin
               ctrl_q <= ctrl_drop;
               if (ctrl_drop == '0) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef MC_STAGE_CTRL_PERF_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (load_ok) begin
         stall_q <= '0;
      end else if ((state_q == StRun) && !step_valid && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule
